// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - instruction store with combinational fetch port and program-load write port
module instruction_memory #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Boot program; every word past the listed ones boots to zero.
  function automatic logic [DATA_W-1:0] boot_word(input int idx);
    logic [15:0] w;
    case (idx)
      0:       w = 16'h1101;
      1:       w = 16'h1202;
      2:       w = 16'h0123;
      3:       w = 16'h2304;
      4:       w = 16'h3405;
      5:       w = 16'h4506;
      6:       w = 16'h5607;
      7:       w = 16'h6708;
      8:       w = 16'hF000;
      default: w = 16'h0000;
    endcase
    return DATA_W'(w);
  endfunction

  // Reset reloads the whole boot image at once; otherwise a write lands on
  // the clock edge. An unknown we fails the if-test, so it never writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= boot_word(i);
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Fetch is a plain array read: no bypass, so a word being written shows its
  // old value until the edge that stores the new one.
  always_comb begin
    data = mem_q[address];
  end

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - directed-vector bench for instruction_memory
`timescale 1ns/1ps
module tb_instruction_memory;

  logic        clk;
  logic        reset;
  logic [7:0]  address;
  logic [15:0] data;
  logic        we;
  logic [7:0]  waddr;
  logic [15:0] wdata;

  int n_vec;
  int n_miss;

  instruction_memory #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .data    (data),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic read_at(input string tag, input logic [7:0] a, input logic [15:0] exp);
    address = a;
    #1;
    check_vec(tag, data, exp);
  endtask

  logic [15:0] boot_exp [9];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    boot_exp = '{16'h1101, 16'h1202, 16'h0123, 16'h2304, 16'h3405,
                 16'h4506, 16'h5607, 16'h6708, 16'hF000};

    reset   = 1'b1;
    we      = 1'b0;
    waddr   = 8'h00;
    wdata   = 16'h0000;
    address = 8'h00;
    #22;
    reset = 1'b0;

    // Boot image sweep, 100 ns per step.
    for (int i = 0; i < 9; i++) begin
      address = 8'(i);
      #100;
      check_vec($sformatf("boot[%0d]", i), data, boot_exp[i]);
    end

    // Zero-filled tail, including the last word.
    read_at("boot[9]",   8'd9,   16'h0000);
    read_at("boot[128]", 8'd128, 16'h0000);
    read_at("boot[255]", 8'd255, 16'h0000);

    // Read-during-write on word 3: old value before the edge, new after.
    @(negedge clk);
    we = 1'b1; waddr = 8'h03; wdata = 16'hABCD; address = 8'h03;
    #1;
    check_vec("rdw_before", data, 16'h2304);
    @(posedge clk);
    #1;
    check_vec("rdw_after", data, 16'hABCD);
    we = 1'b0;
    read_at("neighbour_02", 8'h02, 16'h0123);
    read_at("neighbour_04", 8'h04, 16'h3405);

    // Write BEEF to the last word, then reset asynchronously between edges.
    @(negedge clk);
    we = 1'b1; waddr = 8'hFF; wdata = 16'hBEEF;
    @(posedge clk);
    #1;
    we = 1'b0;
    read_at("write_ff", 8'hFF, 16'hBEEF);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_vec("async_rst_ff", data, 16'h0000);
    read_at("async_rst_03", 8'h03, 16'h2304);

    // Writes ignored while reset is held.
    we = 1'b1; waddr = 8'h00; wdata = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    read_at("rst_blocks_wr", 8'h00, 16'h1101);
    @(negedge clk);
    we = 1'b0;
    reset = 1'b0;

    // Single-edge write, then we low with wdata toggling.
    @(negedge clk);
    we = 1'b1; waddr = 8'h05; wdata = 16'h1234;
    @(posedge clk);
    #1;
    read_at("first_wr_05", 8'h05, 16'h1234);
    @(negedge clk);
    we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wdata = (i % 2 == 0) ? 16'h5555 : 16'hAAAA;
      @(negedge clk);
    end
    read_at("we0_hold_05", 8'h05, 16'h1234);
    read_at("we0_other_06", 8'h06, 16'h5607);

    // Unknown we must not write.
    we = 1'bx; waddr = 8'h06; wdata = 16'hDEAD;
    @(posedge clk);
    #1;
    read_at("we_x_06", 8'h06, 16'h5607);
    we = 1'b0;
    read_at("we_x_05", 8'h05, 16'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
